// File: rtl/bcd_addsub_pkg.sv
// Shared types and constants for the signed BCD add/subtract engine.
// Includes a digit-legality helper used when operands are accepted.
package bcd_addsub_pkg;

  localparam int NDIG_DEF = 3;
  localparam int CNT_W    = $clog2(NDIG_DEF);

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX  = 4'd9;
  localparam digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    DIG,
    DONE
  } state_t;

  // True when every nibble of v is a legal BCD digit.
  function automatic logic bcd_ok(input logic [4*NDIG_DEF-1:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < NDIG_DEF; i++) begin
      if (v[4*i +: 4] > BCD_MAX) bcd_ok = 1'b0;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD adder/subtractor with carry/borrow in and out.
// The top module time-shares one instance across all digit positions.
module bcd_digit_addsub
  import bcd_addsub_pkg::*;
(
  input  digit_t x,
  input  digit_t y,
  input  logic   cin,
  input  logic   sub,
  output digit_t digit,
  output logic   cout
);

  logic [4:0] sum;
  logic [4:0] diff;
  logic [4:0] corr;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    digit = '0;
    cout  = 1'b0;
    sum   = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    diff  = {1'b0, x} - {1'b0, y} - {4'b0, cin};
    corr  = sum + {1'b0, BCD_CORR};
    if (sub) begin
      // A negative difference shows up as bit 4 set; adding ten wraps it back
      // into 0..9 in the low nibble.
      if (diff[4]) begin
        digit = diff[3:0] + 4'd10;
        cout  = 1'b1;
      end else begin
        digit = diff[3:0];
      end
    end else begin
      if (sum > {1'b0, BCD_MAX}) begin
        digit = corr[3:0];
        cout  = 1'b1;
      end else begin
        digit = sum[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_signed_addsub_seq.sv
// Sequential signed NDIG-digit BCD add/subtract, one digit per cycle LSB first.
// Comparator flags order the operands so subtraction always yields a magnitude.
module bcd_signed_addsub_seq
  import bcd_addsub_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic            sign_a,
  input  logic [4*NDIG-1:0] a,
  input  logic            sign_b,
  input  logic [4*NDIG-1:0] b,
  input  logic            cmp_l,
  input  logic            cmp_e,
  input  logic            cmp_g,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            res_sign,
  output logic [4*NDIG-1:0] res,
  output logic            ovf,
  output logic            err
);

  localparam int W = 4 * NDIG;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_sh, y_sh, acc;
  logic             carry, sub_r, sign_r, kill_r, err_r;

  logic             accept, last;
  logic             eff_sub, one_hot, bad, sel_swap, acc_sign;
  digit_t           dig;
  logic             dcout;
  logic [W-1:0]     acc_nxt;
  logic             fin_ovf;

  assign accept  = in_valid & in_ready;
  assign last    = (cnt == CNT_W'(NDIG - 1));
  assign acc_nxt = {dig, acc[W-1:4]};
  assign fin_ovf = ~sub_r & dcout;
  assign err     = err_r;

  // Operand ordering and error detection, evaluated on the accept cycle.
  always_comb begin
    eff_sub  = sign_a ^ sign_b ^ op;
    one_hot  = ({cmp_l, cmp_e, cmp_g} == 3'b100) ||
               ({cmp_l, cmp_e, cmp_g} == 3'b010) ||
               ({cmp_l, cmp_e, cmp_g} == 3'b001);
    bad      = !bcd_ok(a) || !bcd_ok(b) || !one_hot;
    sel_swap = eff_sub & cmp_l;
    acc_sign = sel_swap ? (sign_b ^ op) : sign_a;
  end

  bcd_digit_addsub u_digit (
    .x     (x_sh[3:0]),
    .y     (y_sh[3:0]),
    .cin   (carry),
    .sub   (sub_r),
    .digit (dig),
    .cout  (dcout)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DIG;
      end
      DIG: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      x_sh     <= '0;
      y_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      sub_r    <= 1'b0;
      sign_r   <= 1'b0;
      kill_r   <= 1'b0;
      err_r    <= 1'b0;
      res      <= '0;
      res_sign <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        x_sh   <= sel_swap ? b : a;
        y_sh   <= sel_swap ? a : b;
        acc    <= '0;
        carry  <= 1'b0;
        sub_r  <= eff_sub;
        sign_r <= acc_sign;
        // Equal magnitudes under subtraction and any error force a clean zero.
        kill_r <= bad | (eff_sub & cmp_e);
        err_r  <= bad;
      end else if (state == DIG) begin
        cnt   <= cnt + 1'b1;
        x_sh  <= x_sh >> 4;
        y_sh  <= y_sh >> 4;
        acc   <= acc_nxt;
        carry <= dcout;
        if (last) begin
          res      <= kill_r ? '0 : acc_nxt;
          ovf      <= ~kill_r & fin_ovf;
          // A true zero never carries a negative sign.
          res_sign <= (kill_r || (acc_nxt == '0 && !fin_ovf)) ? 1'b0 : sign_r;
        end
      end else if (state == DONE && out_ready) begin
        err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_signed_addsub_seq.sv
// Directed bench for bcd_signed_addsub_seq with an arithmetic reference model
// feeding a scoreboard queue that is drained as results appear.
module tb_bcd_signed_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op, sign_a, sign_b;
  logic [11:0] a, b, res;
  logic        cmp_l, cmp_e, cmp_g;
  logic        out_valid, out_ready, res_sign, ovf, err;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [11:0] res;
    logic        sign;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bcd_signed_addsub_seq #(.NDIG(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sign_a    (sign_a),
    .a         (a),
    .sign_b    (sign_b),
    .b         (b),
    .cmp_l     (cmp_l),
    .cmp_e     (cmp_e),
    .cmp_g     (cmp_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_sign  (res_sign),
    .res       (res),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int n);
    return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Reference: plain signed integer arithmetic on the decoded operands.
  function automatic exp_t model(input logic o, input logic sa, input logic [11:0] av,
                                 input logic sb, input logic [11:0] bv,
                                 input logic l, input logic e, input logic g);
    exp_t r;
    int   x, y, s, mag;
    logic bad;
    bad = (int'(l) + int'(e) + int'(g)) != 1;
    for (int i = 0; i < 3; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    r.err = bad;
    if (bad) begin
      r.res = '0; r.sign = 1'b0; r.ovf = 1'b0;
      return r;
    end
    x   = sa ? -bcd2int(av) : bcd2int(av);
    y   = sb ? -bcd2int(bv) : bcd2int(bv);
    s   = o ? x - y : x + y;
    mag = (s < 0) ? -s : s;
    r.ovf  = mag > 999;
    r.res  = int2bcd(mag % 1000);
    r.sign = (s < 0);
    return r;
  endfunction

  task automatic run_op(input logic o, input logic sa, input logic [11:0] av,
                        input logic sb, input logic [11:0] bv,
                        input logic l, input logic e, input logic g, input int hold);
    exp_t ex;
    int   edges;
    @(negedge clk);
    out_ready = (hold == 0);
    op = o; sign_a = sa; a = av; sign_b = sb; b = bv;
    cmp_l = l; cmp_e = e; cmp_g = g;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    sb_q.push_back(model(o, sa, av, sb, bv, l, e, g));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    // Count edges from the accept edge (inclusive) until out_valid appears.
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency_edges", 32'(edges), 32'd4);
    ex = '{res: 12'hFFF, sign: 1'bx, ovf: 1'bx, err: 1'bx};
    if (sb_q.size() > 0) ex = sb_q.pop_front();
    chk("res", 32'(res), 32'(ex.res));
    chk("res_sign", 32'(res_sign), 32'(ex.sign));
    chk("ovf", 32'(ovf), 32'(ex.ovf));
    chk("err", 32'(err), 32'(ex.err));
    if (hold > 0) begin
      // Stalled consumer; a competing operand set must be ignored.
      a = 12'h111; b = 12'h222; cmp_l = 1'b1; cmp_e = 1'b0; cmp_g = 1'b0;
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_res", 32'(res), 32'(ex.res));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_valid", 32'(out_valid), 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("no_ghost_op", 32'(out_valid), 32'd0);
    end else begin
      @(posedge clk);
      @(negedge clk);
      chk("back_to_idle", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [11:0] ra, rb;
    logic        ro, rsa, rsb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 1'b0; sign_a = 1'b0; sign_b = 1'b0; a = '0; b = '0;
    cmp_l = 1'b0; cmp_e = 1'b0; cmp_g = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_sign", 32'(res_sign), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b1, 1'b0, 1'b0, 0);
    run_op(1'b1, 1'b0, 12'h123, 1'b0, 12'h456, 1'b1, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b1, 12'h700, 1'b0, 12'h250, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 1'b1, 12'h500, 1'b0, 12'h500, 1'b0, 1'b1, 1'b0, 0);
    run_op(1'b0, 1'b0, 12'h999, 1'b0, 12'h001, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 1'b0, 12'h555, 1'b0, 12'h445, 1'b0, 1'b0, 1'b1, 0);
    run_op(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 0);
    run_op(1'b1, 1'b1, 12'h208, 1'b1, 12'h019, 1'b0, 1'b0, 1'b1, 0);

    run_op(1'b0, 1'b0, 12'h321, 1'b0, 12'h111, 1'b0, 1'b0, 1'b1, 3);

    run_op(1'b0, 1'b0, 12'h0A3, 1'b0, 12'h100, 1'b1, 1'b0, 1'b0, 0);
    run_op(1'b1, 1'b0, 12'h300, 1'b0, 12'h100, 1'b1, 1'b0, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      ra  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rb  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ro  = 1'($urandom_range(0, 1));
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      run_op(ro, rsa, ra, rsb, rb, bcd2int(ra) < bcd2int(rb),
             bcd2int(ra) == bcd2int(rb), bcd2int(ra) > bcd2int(rb), 0);
    end

    // Reset in the middle of the digit phase abandons the operation.
    @(negedge clk);
    op = 1'b0; sign_a = 1'b0; a = 12'h246; sign_b = 1'b0; b = 12'h135;
    cmp_l = 1'b0; cmp_e = 1'b0; cmp_g = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 1'b0, 12'h001, 1'b0, 12'h001, 1'b0, 1'b1, 1'b0, 0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
